sprite_pixel_fetch: RTL and testbench
=====================================

Name: sprite_pixel_fetch

Overview:
- Upstream stage of the per-character palette lookup. Converts the VGA beam position into a sprite-ROM address and returns the 4-bit colour index, plus hit and opaque flags, to the palette stage and the pixel mixer.
- Latches sprite position and facing at vsync so a frame never tears.
- Runs the attack-animation frame sequencer (for example, crouch-punch frames).

Parameters:
- SPR_W, 64, sprite width in pixels (power of 2)
- SPR_H, 64, sprite height in pixels
- FRAMES, 4, animation frames stored back-to-back in the ROM
- FRAME_HOLD, 6, vsyncs each animation frame is displayed (must be at least 1)
- ADDR_W, 14, ROM address width (must be at least clog2(FRAMES*SPR_W*SPR_H))

Ports:
- Clk  in  1  system/pixel clock
- Reset  in  1  synchronous, active-high reset
- DrawX  in  10  current beam column
- DrawY  in  10  current beam row
- vsync_pulse  in  1  one-cycle strobe at start of vertical blank
- sprite_x  in  10  requested sprite left edge
- sprite_y  in  10  requested sprite top edge
- flip_in  in  1  1 = mirror horizontally (facing left)
- anim_start  in  1  one-cycle request to play the animation
- rom_addr  out  ADDR_W  registered address to synchronous sprite ROM
- rom_data  in  4  ROM colour index, valid 1 clock after rom_addr
- index_out  out  4  colour index to palette stage
- hit_out  out  1  pixel lies inside the sprite box
- opaque_out  out  1  hit_out and index_out != 0 (index 0 = transparent key)
- anim_busy  out  1  animation FSM is in PLAY
- anim_frame  out  clog2(FRAMES)  frame currently being displayed

Behaviour:
- Reset (synchronous, active-high) forces the following to 0: rom_addr, index_out, hit_out, opaque_out, anim_busy, anim_frame, the latched x/y/flip/frame values, the hold counter and all pipeline valid bits. FSM returns to IDLE. Reset asserted mid-animation aborts it immediately.
- Latch: on vsync_pulse, x_lat<=sprite_x, y_lat<=sprite_y, flip_lat<=flip_in, frame_lat<=anim_frame (the value before any update in the same cycle). All address math uses only latched values.
- Stage 0 (combinational, 11-bit unsigned):
  - relX = DrawX - x_lat; relY = DrawY - y_lat.
  - hit0 = (DrawX >= x_lat) && (relX < SPR_W) && (DrawY >= y_lat) && (relY < SPR_H).
  - col = flip_lat ? SPR_W-1-relX : relX.
  - addr0 = frame_lat*SPR_W*SPR_H + relY*SPR_W + col, truncated to ADDR_W.
  - When hit0 = 0, addr0 = 0.
- Cycle t+1: rom_addr <= addr0; hit1 <= hit0.
- Cycle t+2: rom_data is valid; hit2 <= hit1.
- Cycle t+3:
  - index_out <= hit2 ? rom_data : 0
  - hit_out <= hit2
  - opaque_out <= hit2 && (rom_data != 0)
- Fixed latency: 3 clocks from DrawX/DrawY to index_out. Fully pipelined, one pixel per clock, no stalls.
- Sprite boxes that extend past the screen edge need no special handling. X wrap is impossible because the 11-bit compare is used.
- Animation FSM:
  - IDLE: anim_frame=0, anim_busy=0. anim_start -> PLAY with anim_frame=0 and hold=0. When anim_start and vsync_pulse coincide, that vsync is not counted.
  - PLAY: anim_busy=1; each vsync_pulse increments hold.
    - When hold reaches FRAME_HOLD-1 on a vsync: hold<=0.
    - If anim_frame < FRAMES-1: anim_frame++.
    - Else: go to IDLE with anim_frame<=0.
  - anim_start during PLAY is ignored (see optional feature).
- The displayed frame changes only at vsync, through frame_lat, so the image stays one frame behind anim_frame.

Optional Feature:
- Macro SPRITE_ANIM_LOOP_EN.
- Defined: after the last frame's hold expires, PLAY wraps to anim_frame=0 and stays in PLAY (idle/breathing loop). anim_busy stays 1 until Reset. anim_start in PLAY restarts at frame 0 with hold=0.
- Undefined: behaviour exactly as above (one-shot playback, anim_start ignored in PLAY).

Test Plan:
- Reset sequence -> all outputs 0 and FSM in IDLE. After 3 idle clocks, index_out=0 and hit_out=0.
- Position and address: latch x=100, y=50 via vsync, frame 0. Drive DrawX=105, DrawY=53, rom_data returning 4'h7 -> rom_addr=3*64+5=197 at t+1; index_out=7, hit_out=1, opaque_out=1 at t+3.
- Flip and bounds: flip=1, same position, DrawX=105 -> rom_addr=3*64+58=250. DrawX=99 or 164 -> hit_out=0, index_out=0. rom_data=0 inside the box -> hit_out=1, opaque_out=0.
- Tear-free latch: change sprite_x to 300 mid-frame -> addresses still use x=100 until the next vsync_pulse, then use x=300.
- Animation: anim_start, then 24 vsyncs with FRAME_HOLD=6 -> anim_frame steps 0,1,2,3 every 6 vsyncs, returns to IDLE and anim_busy drops at vsync 24. At frame 2, row 3, col 5 -> rom_addr=8389. anim_start issued at vsync 10 is ignored.
- Corner cases: anim_start coincident with vsync -> frame 0 is held a full 6 vsyncs. Reset at vsync 8 -> anim_frame=0 and anim_busy=0 next clock. With SPRITE_ANIM_LOOP_EN, vsync 24 -> anim_frame=0 and anim_busy=1.

Source files
------------

// File: rtl/sprite_pixel_fetch.sv
// Beam position -> sprite ROM address -> colour index/hit/opaque, 3-clock fixed latency, no stalls.
// Also runs the vsync-paced attack animation sequencer; define SPRITE_ANIM_LOOP_EN for looping playback.
module sprite_pixel_fetch #(
    parameter int SPR_W      = 64,
    parameter int SPR_H      = 64,
    parameter int FRAMES     = 4,
    parameter int FRAME_HOLD = 6,
    parameter int ADDR_W     = 14,
    localparam int FRAME_W   = (FRAMES > 1) ? $clog2(FRAMES) : 1
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic [9:0]         DrawX,
    input  logic [9:0]         DrawY,
    input  logic               vsync_pulse,
    input  logic [9:0]         sprite_x,
    input  logic [9:0]         sprite_y,
    input  logic               flip_in,
    input  logic               anim_start,
    output logic [ADDR_W-1:0]  rom_addr,
    input  logic [3:0]         rom_data,
    output logic [3:0]         index_out,
    output logic               hit_out,
    output logic               opaque_out,
    output logic               anim_busy,
    output logic [FRAME_W-1:0] anim_frame
);

    localparam int HOLD_W = $clog2(FRAME_HOLD + 1);
    localparam logic [HOLD_W-1:0]  HOLD_LAST  = HOLD_W'(FRAME_HOLD - 1);
    localparam logic [FRAME_W-1:0] FRAME_LAST = FRAME_W'(FRAMES - 1);

    typedef enum logic {S_IDLE, S_PLAY} state_t;

    state_t              state_q;
    logic [HOLD_W-1:0]   hold_q;
    logic [FRAME_W-1:0]  anim_frame_q;
    logic                anim_busy_q;

    logic [9:0]          x_lat_q, x_lat_d;
    logic [9:0]          y_lat_q, y_lat_d;
    logic                flip_lat_q, flip_lat_d;
    logic [FRAME_W-1:0]  frame_lat_q, frame_lat_d;

    logic [ADDR_W-1:0]   rom_addr_q, rom_addr_d;
    logic                hit1_q, hit1_d;
    logic                hit2_q, hit2_d;
    logic [3:0]          index_q, index_d;
    logic                hit_out_q, hit_out_d;
    logic                opaque_q, opaque_d;

    logic [10:0]         rel_x, rel_y, col;
    logic                hit0;
    logic [31:0]         addr_full;

    // Position/facing/frame only move at vsync so a frame never mixes two poses.
    always_comb begin
        x_lat_d     = x_lat_q;
        y_lat_d     = y_lat_q;
        flip_lat_d  = flip_lat_q;
        frame_lat_d = frame_lat_q;
        if (vsync_pulse) begin
            x_lat_d     = sprite_x;
            y_lat_d     = sprite_y;
            flip_lat_d  = flip_in;
            frame_lat_d = anim_frame_q;
        end
    end

    // 11-bit compares keep a box hanging off the right/bottom edge from wrapping.
    always_comb begin
        rel_x     = {1'b0, DrawX} - {1'b0, x_lat_q};
        rel_y     = {1'b0, DrawY} - {1'b0, y_lat_q};
        hit0      = (DrawX >= x_lat_q) && (rel_x < 11'(SPR_W)) &&
                    (DrawY >= y_lat_q) && (rel_y < 11'(SPR_H));
        col       = flip_lat_q ? (11'(SPR_W - 1) - rel_x) : rel_x;
        addr_full = 32'(frame_lat_q) * 32'(SPR_W * SPR_H)
                  + 32'(rel_y) * 32'(SPR_W) + 32'(col);
        rom_addr_d = hit0 ? addr_full[ADDR_W-1:0] : '0;
        hit1_d     = hit0;
        hit2_d     = hit1_q;
        index_d    = hit2_q ? rom_data : 4'h0;
        hit_out_d  = hit2_q;
        opaque_d   = hit2_q && (rom_data != 4'h0);
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            x_lat_q     <= '0;
            y_lat_q     <= '0;
            flip_lat_q  <= 1'b0;
            frame_lat_q <= '0;
            rom_addr_q  <= '0;
            hit1_q      <= 1'b0;
            hit2_q      <= 1'b0;
            index_q     <= 4'h0;
            hit_out_q   <= 1'b0;
            opaque_q    <= 1'b0;
        end else begin
            x_lat_q     <= x_lat_d;
            y_lat_q     <= y_lat_d;
            flip_lat_q  <= flip_lat_d;
            frame_lat_q <= frame_lat_d;
            rom_addr_q  <= rom_addr_d;
            hit1_q      <= hit1_d;
            hit2_q      <= hit2_d;
            index_q     <= index_d;
            hit_out_q   <= hit_out_d;
            opaque_q    <= opaque_d;
        end
    end

    // A start that lands on a vsync does not count that vsync toward frame 0's hold.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q      <= S_IDLE;
            hold_q       <= '0;
            anim_frame_q <= '0;
            anim_busy_q  <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (anim_start) begin
                        state_q      <= S_PLAY;
                        anim_busy_q  <= 1'b1;
                        anim_frame_q <= '0;
                        hold_q       <= '0;
                    end
                end
                default: begin
`ifdef SPRITE_ANIM_LOOP_EN
                    if (anim_start) begin
                        anim_frame_q <= '0;
                        hold_q       <= '0;
                    end else
`endif
                    if (vsync_pulse) begin
                        if (hold_q == HOLD_LAST) begin
                            hold_q <= '0;
                            if (anim_frame_q < FRAME_LAST) begin
                                anim_frame_q <= anim_frame_q + 1'b1;
                            end else begin
                                anim_frame_q <= '0;
`ifndef SPRITE_ANIM_LOOP_EN
                                state_q      <= S_IDLE;
                                anim_busy_q  <= 1'b0;
`endif
                            end
                        end else begin
                            hold_q <= hold_q + 1'b1;
                        end
                    end
                end
            endcase
        end
    end

    assign rom_addr   = rom_addr_q;
    assign index_out  = index_q;
    assign hit_out    = hit_out_q;
    assign opaque_out = opaque_q;
    assign anim_busy  = anim_busy_q;
    assign anim_frame = anim_frame_q;

endmodule

// File: tb/tb_sprite_pixel_fetch.sv
// Randomised + directed bench for sprite_pixel_fetch with a queue scoreboard and an
// abstract model: vsync counting for the animation, direct box geometry for pixels.
module tb_sprite_pixel_fetch;

    localparam int SPR_W  = 64;
    localparam int SPR_H  = 64;
    localparam int FRAMES = 4;
    localparam int FH     = 6;
    localparam int ADDR_W = 14;
    localparam int FRAME_W = 2;

    logic              Clk = 1'b0;
    logic              Reset = 1'b1;
    logic [9:0]        DrawX = '0, DrawY = '0, sprite_x = '0, sprite_y = '0;
    logic              vsync_pulse = 1'b0, flip_in = 1'b0, anim_start = 1'b0;
    logic [ADDR_W-1:0] rom_addr;
    logic [3:0]        rom_data = 4'h0;
    logic [3:0]        index_out;
    logic              hit_out, opaque_out, anim_busy;
    logic [FRAME_W-1:0] anim_frame;

    sprite_pixel_fetch #(
        .SPR_W(SPR_W), .SPR_H(SPR_H), .FRAMES(FRAMES),
        .FRAME_HOLD(FH), .ADDR_W(ADDR_W)
    ) dut (
        .Clk(Clk), .Reset(Reset), .DrawX(DrawX), .DrawY(DrawY),
        .vsync_pulse(vsync_pulse), .sprite_x(sprite_x), .sprite_y(sprite_y),
        .flip_in(flip_in), .anim_start(anim_start), .rom_addr(rom_addr),
        .rom_data(rom_data), .index_out(index_out), .hit_out(hit_out),
        .opaque_out(opaque_out), .anim_busy(anim_busy), .anim_frame(anim_frame)
    );

    always #5 Clk = ~Clk;

    logic [3:0] rom_mem [0:(1<<ADDR_W)-1];
    always @(posedge Clk) rom_data <= rom_mem[rom_addr];

    int cyc = 0;
    always @(posedge Clk) cyc = cyc + 1;

    typedef struct {
        int          due;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] c;
    } ent_t;
    ent_t early_q[$];
    ent_t late_q[$];

    int n_vec = 0;
    int n_err = 0;

    // Reference state
    int m_x = 0, m_y = 0, m_fl = 0, m_fr = 0;
    int m_active = 0, m_nvs = 0;

    function automatic int m_frame();
        if (m_active == 0) return 0;
`ifdef SPRITE_ANIM_LOOP_EN
        return (m_nvs / FH) % FRAMES;
`else
        return m_nvs / FH;
`endif
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s cyc=%0d got=%0d want=%0d", name, cyc, act, exp);
        end
    endtask

    always @(negedge Clk) begin
        ent_t e;
        while (early_q.size() > 0 && early_q[0].due <= cyc) begin
            e = early_q.pop_front();
            if (e.due < cyc) begin
                n_vec++; n_err++;
                $display("FAIL early_missed due=%0d cyc=%0d", e.due, cyc);
            end else begin
                chk("rom_addr", 32'(rom_addr), e.a);
                chk("anim_frame", 32'(anim_frame), e.b);
                chk("anim_busy", 32'(anim_busy), e.c);
            end
        end
        while (late_q.size() > 0 && late_q[0].due <= cyc) begin
            e = late_q.pop_front();
            if (e.due < cyc) begin
                n_vec++; n_err++;
                $display("FAIL late_missed due=%0d cyc=%0d", e.due, cyc);
            end else begin
                chk("index_out", 32'(index_out), e.a);
                chk("hit_out", 32'(hit_out), e.b);
                chk("opaque_out", 32'(opaque_out), e.c);
            end
        end
    end

    // One clock of stimulus: expectations come from the model state before this cycle's events.
    task automatic step(input logic rst, input logic vs, input logic st,
                        input logic [9:0] dx, input logic [9:0] dy,
                        input logic [9:0] sx, input logic [9:0] sy, input logic fl);
        ent_t e, l;
        int rx, ry, col, addr, h, cur;
        Reset = rst; vsync_pulse = vs; anim_start = st;
        DrawX = dx; DrawY = dy; sprite_x = sx; sprite_y = sy; flip_in = fl;
        rx = int'(dx) - m_x;
        ry = int'(dy) - m_y;
        h = (rx >= 0 && rx < SPR_W && ry >= 0 && ry < SPR_H) ? 1 : 0;
        col = (m_fl != 0) ? (SPR_W - 1 - rx) : rx;
        addr = h ? ((m_fr * SPR_W * SPR_H + ry * SPR_W + col) % (1 << ADDR_W)) : 0;
        if (rst) begin
            for (int i = 0; i < late_q.size(); i++) begin
                if (late_q[i].due >= cyc + 1) begin
                    late_q[i].a = 0; late_q[i].b = 0; late_q[i].c = 0;
                end
            end
            m_x = 0; m_y = 0; m_fl = 0; m_fr = 0; m_active = 0; m_nvs = 0;
            h = 0; addr = 0;
        end else begin
            cur = m_frame();
            if (vs) begin
                m_x = int'(sx); m_y = int'(sy); m_fl = int'(fl); m_fr = cur;
            end
            if (m_active == 0) begin
                if (st) begin m_active = 1; m_nvs = 0; end
            end else begin
`ifdef SPRITE_ANIM_LOOP_EN
                if (st) m_nvs = 0;
                else if (vs) m_nvs = (m_nvs + 1) % (FRAMES * FH);
`else
                if (vs) begin
                    m_nvs++;
                    if (m_nvs == FRAMES * FH) begin m_active = 0; m_nvs = 0; end
                end
`endif
            end
        end
        e.due = cyc + 1; e.a = 32'(addr); e.b = 32'(m_frame()); e.c = 32'(m_active);
        l.due = cyc + 3;
        l.a = h ? 32'(rom_mem[addr]) : 32'd0;
        l.b = 32'(h);
        l.c = (h != 0 && rom_mem[addr] != 4'h0) ? 32'd1 : 32'd0;
        early_q.push_back(e);
        late_q.push_back(l);
        @(posedge Clk);
        #1;
    endtask

    logic [9:0] sx_r = 10'd100, sy_r = 10'd50;
    logic       fl_r = 1'b0;

    task automatic pix(input int ox, input int oy);
        step(1'b0, 1'b0, 1'b0, sx_r + 10'(ox), sy_r + 10'(oy), sx_r, sy_r, fl_r);
    endtask

    task automatic vs_step(input logic st);
        step(1'b0, 1'b1, st, 10'(sx_r + 5), 10'(sy_r + 3), sx_r, sy_r, fl_r);
    endtask

    initial begin
        for (int i = 0; i < (1 << ADDR_W); i++)
            rom_mem[i] = ($urandom_range(0, 3) == 0) ? 4'h0 : 4'($urandom);
        rom_mem[197] = 4'h7;
        rom_mem[250] = 4'h0;

        // Reset then idle
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 10'd500, 10'd400, 10'd0, 10'd0, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 10'd500, 10'd400, 10'd0, 10'd0, 1'b0);

        // Position, flip and bounds
        vs_step(1'b0);
        pix(5, 3); pix(-1, 3); pix(64, 3); pix(0, 0); pix(63, 63); pix(5, 64);
        fl_r = 1'b1; vs_step(1'b0);
        pix(5, 3); pix(-1, 3); pix(64, 3); pix(58, 3); pix(0, 10);

        // Tear-free latch: new x only after the next vsync
        fl_r = 1'b0;
        step(1'b0, 1'b0, 1'b0, 10'd105, 10'd53, 10'd300, 10'd50, 1'b0);
        step(1'b0, 1'b0, 1'b0, 10'd305, 10'd53, 10'd300, 10'd50, 1'b0);
        sx_r = 10'd300; vs_step(1'b0);
        pix(5, 3); step(1'b0, 1'b0, 1'b0, 10'd105, 10'd53, sx_r, sy_r, 1'b0);

        // One-shot animation with a stray start at vsync 10
        step(1'b0, 1'b0, 1'b1, 10'd0, 10'd0, sx_r, sy_r, fl_r);
        for (int v = 1; v <= 26; v++) begin
            vs_step(v == 10);
            pix(5, 3); pix($urandom_range(0, 70), $urandom_range(0, 70));
        end

        // Start coincident with vsync
        vs_step(1'b1);
        for (int v = 1; v <= 8; v++) begin vs_step(1'b0); pix(5, 3); end
        // Reset at vsync 8 of a fresh run
        for (int i = 0; i < 30; i++) vs_step(1'b0);
        step(1'b0, 1'b0, 1'b1, 10'd0, 10'd0, sx_r, sy_r, fl_r);
        for (int v = 1; v <= 7; v++) begin vs_step(1'b0); pix(5, 3); end
        step(1'b1, 1'b1, 1'b0, 10'd5, 10'd3, sx_r, sy_r, fl_r);
        pix(5, 3); pix(1, 1); vs_step(1'b0); pix(5, 3);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            logic rst, vs, st;
            rst = ($urandom_range(0, 800) == 0);
            vs  = ($urandom_range(0, 30) == 0);
            st  = ($urandom_range(0, 150) == 0);
            if ($urandom_range(0, 20) == 0) begin
                sx_r = 10'($urandom); sy_r = 10'($urandom); fl_r = 1'($urandom);
            end
            step(rst, vs, st, 10'(sx_r + 10'($urandom_range(0, 80)) - 10'd8),
                 10'(sy_r + 10'($urandom_range(0, 80)) - 10'd8), sx_r, sy_r, fl_r);
        end

        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b0, 10'd0, 10'd0, sx_r, sy_r, fl_r);
        repeat (5) @(posedge Clk);
        #1;
        if (early_q.size() + late_q.size() > 0) begin
            n_vec++; n_err++;
            $display("FAIL drain left=%0d want=0", early_q.size() + late_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
